// File: rtl/jk_cmd_seq.sv
// Purpose: command sequencer that drives j/k of a JK flip-flop and checks the returned q/qn against a reference model.
// Latency: j/k appear the cycle after accept and last max(len,1) cycles; done pulses the cycle after the last drive cycle.
// Backpressure: cmd_ready is low for the whole drive window, so at least one idle j=k=0 cycle separates commands.
`timescale 1ns/1ps
module jk_cmd_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_len,
  output logic             j,
  output logic             k,
  input  logic             q_in,
  input  logic             qn_in,
  input  logic             clr_err,
  output logic             busy,
  output logic             done,
  output logic             exp_q,
  output logic             synced,
  output logic             err,
  output logic [7:0]       err_cnt
);

  typedef enum logic {IDLE = 1'b0, DRIVE = 1'b1} state_e;

  localparam logic [1:0]       OP_RESET = 2'd1;
  localparam logic [1:0]       OP_SET   = 2'd2;
  localparam logic [1:0]       OP_TOG   = 2'd3;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]       ERR_MAX  = 8'hFF;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             j_q, j_d, k_q, k_d;
  logic             done_q, done_d;
  logic             exp_q_q, exp_q_d;
  logic             synced_q, synced_d;
  logic             err_q, err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             mismatch;

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == DRIVE);
  assign j         = j_q;
  assign k         = k_q;
  assign done      = done_q;
  assign exp_q     = exp_q_q;
  assign synced    = synced_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

  // Sequencer next state: accept in IDLE, count down in DRIVE, and advance the flip-flop model on every drive edge.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    j_d      = 1'b0;
    k_d      = 1'b0;
    done_d   = 1'b0;
    exp_q_d  = exp_q_q;
    synced_d = synced_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = DRIVE;
          op_d    = cmd_op;
          // A zero length still drives one cycle so every command is visible at the flip-flop.
          cnt_d   = (cmd_len == '0) ? CNT_ONE : cmd_len;
          j_d     = cmd_op[1];
          k_d     = cmd_op[0];
        end
      end
      DRIVE: begin
        cnt_d = cnt_q - CNT_ONE;
        // The flip-flop samples j/k at this same edge, so the model moves in lockstep with it.
        case (op_q)
          OP_RESET: begin exp_q_d = 1'b0;     synced_d = 1'b1; end
          OP_SET:   begin exp_q_d = 1'b1;     synced_d = 1'b1; end
          OP_TOG:   begin exp_q_d = ~exp_q_q;                  end
          default:  begin                                      end
        endcase
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          j_d = op_q[1];
          k_d = op_q[0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Checker next state: q vs model only once the model is known; q == qn is always illegal.
  always_comb begin
    mismatch  = (synced_q && (q_in != exp_q_q)) || (qn_in == q_in);
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (clr_err) begin
      err_d     = 1'b0;
      err_cnt_d = 8'd0;
    end else if (mismatch) begin
      err_d = 1'b1;
      if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // State registers; reset aborts any command in flight and forgets the model state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= 2'd0;
      cnt_q     <= '0;
      j_q       <= 1'b0;
      k_q       <= 1'b0;
      done_q    <= 1'b0;
      exp_q_q   <= 1'b0;
      synced_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      j_q       <= j_d;
      k_q       <= k_d;
      done_q    <= done_d;
      exp_q_q   <= exp_q_d;
      synced_q  <= synced_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Purpose: randomized and directed bench for jk_cmd_seq with a behavioural JK flip-flop and a command scoreboard.
// Latency: each command's expected drive length and final model state are checked when its done pulse appears.
// Backpressure: commands are held on cmd_valid until a cycle with cmd_ready high, sometimes back-to-back.
`timescale 1ns/1ps
module tb_jk_cmd_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_len;
  logic       j, k, q_in, qn_in, clr_err;
  logic       busy, done, exp_q, synced, err;
  logic [7:0] err_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] op;
    int         n;
    logic       q_after;
    logic       sync_after;
  } cmd_t;

  cmd_t sb[$];
  cmd_t cur;
  bit   cur_act = 0;
  int   cyc = 0;

  logic m_q = 1'b0;
  logic m_sync = 1'b0;

  logic ff_q = 1'b0;
  logic force_q0 = 1'b0;
  logic force_q_wrong = 1'b0;
  logic force_qn_eq = 1'b0;

  jk_cmd_seq #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .j(j), .k(k), .q_in(q_in), .qn_in(qn_in),
    .clr_err(clr_err), .busy(busy), .done(done), .exp_q(exp_q), .synced(synced),
    .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural JK flip-flop fed by the DUT's drive.
  always @(posedge clk) begin
    case ({j, k})
      2'b01:   ff_q <= 1'b0;
      2'b10:   ff_q <= 1'b1;
      2'b11:   ff_q <= ~ff_q;
      default: ff_q <= ff_q;
    endcase
  end

  // Feedback path with fault injection.
  always_comb begin
    q_in  = force_q0 ? 1'b0 : (force_q_wrong ? ~ff_q : ff_q);
    qn_in = force_qn_eq ? q_in : ~q_in;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // Monitor: pops a command when drive starts, checks j/k each cycle and the outcome at done.
  always @(negedge clk) begin
    if (!rst_n) begin
      cur_act = 0;
      sb.delete();
      chk("reset_done", {31'd0, done}, 0);
    end else begin
      if (busy) begin
        if (!cur_act) begin
          if (sb.size() == 0) chk("unexpected_busy", 1, 0);
          else begin
            cur = sb.pop_front();
            cur_act = 1;
            cyc = 0;
          end
        end
        if (cur_act) begin
          chk("drive_jk", {30'd0, j, k}, {30'd0, cur.op});
          cyc++;
        end
      end else begin
        chk("idle_jk", {30'd0, j, k}, 0);
      end
      if (done) begin
        if (!cur_act) chk("unexpected_done", 1, 0);
        else begin
          chk("drive_cycles", cyc, cur.n);
          chk("done_exp_q", {31'd0, exp_q}, {31'd0, cur.q_after});
          chk("done_synced", {31'd0, synced}, {31'd0, cur.sync_after});
          chk("done_ready", {31'd0, cmd_ready}, 1);
          cur_act = 0;
        end
      end
    end
  end

  // Issue one command; the expected outcome comes from the opcode rules applied to the model state.
  task automatic send(input logic [1:0] op, input int len, input bit keep);
    cmd_t c;
    bit   rdy;
    int   waited = 0;
    c.op = op;
    c.n  = (len == 0) ? 1 : len;
    case (op)
      2'd1:    m_q = 1'b0;
      2'd2:    m_q = 1'b1;
      2'd3:    m_q = m_q ^ c.n[0];
      default: m_q = m_q;
    endcase
    if (op == 2'd1 || op == 2'd2) m_sync = 1'b1;
    c.q_after    = m_q;
    c.sync_after = m_sync;
    sb.push_back(c);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = 8'(len);
    do begin
      @(negedge clk);
      rdy = cmd_ready;
      @(posedge clk);
      waited++;
    end while (!rdy && waited < 1000);
    if (!rdy) chk("accept_timeout", 1, 0);
    #1;
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || cur_act || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("idle_timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_len = 8'd0; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ready", {31'd0, cmd_ready}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_jk", {30'd0, j, k}, 0);
    chk("rst_exp_q", {31'd0, exp_q}, 0);
    chk("rst_synced", {31'd0, synced}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_err_cnt", {24'd0, err_cnt}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // SET 3, TOGGLE 4, HOLD 0 issued back-to-back with valid held high
    send(2'd2, 3, 1);
    send(2'd3, 4, 1);
    send(2'd0, 0, 0);
    wait_idle();
    chk("seq_err", {31'd0, err}, 0);
    chk("seq_err_cnt", {24'd0, err_cnt}, 0);
    chk("seq_exp_q", {31'd0, exp_q}, 1);

    // Randomized commands against a correct flip-flop
    for (int i = 0; i < 40; i++) begin
      send(2'($urandom_range(0, 3)), int'($urandom_range(0, 6)), bit'($urandom_range(0, 1)));
      if (!cmd_valid) repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    send(2'd0, 255, 0);
    wait_idle();
    chk("rand_err_cnt", {24'd0, err_cnt}, 0);
    chk("rand_exp_q", {31'd0, exp_q}, {31'd0, m_q});

    // Unsynced: wrong q is tolerated, q == qn is not
    rst_n = 1'b0; m_q = 1'b0; m_sync = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    force_q_wrong = 1'b1;
    send(2'd3, 5, 0);
    wait_idle();
    chk("unsync_err", {31'd0, err}, 0);
    force_qn_eq = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    force_qn_eq = 1'b0;
    chk("qn_err", {31'd0, err}, 1);
    chk("qn_err_cnt", {24'd0, err_cnt}, 2);
    force_qn_eq = 1'b1; clr_err = 1'b1;
    @(posedge clk); #1;
    force_qn_eq = 1'b0; clr_err = 1'b0;
    chk("clr_err", {31'd0, err}, 0);
    chk("clr_err_cnt", {24'd0, err_cnt}, 0);
    @(posedge clk); #1;
    chk("clr_err_cnt_hold", {24'd0, err_cnt}, 0);
    force_q_wrong = 1'b0;

    // Synced with exp_q=1, hold q low long enough to saturate
    send(2'd2, 1, 0);
    wait_idle();
    chk("sat_pre_err", {31'd0, err}, 0);
    force_q0 = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    force_q0 = 1'b0;
    chk("sat_err_cnt", {24'd0, err_cnt}, 255);
    chk("sat_err", {31'd0, err}, 1);
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    chk("sat_clr", {24'd0, err_cnt}, 0);

    // Reset in the second drive cycle of SET 10
    send(2'd2, 10, 0);
    @(posedge clk); #1;
    rst_n = 1'b0; m_q = 1'b0; m_sync = 1'b0;
    #1;
    chk("abort_jk", {30'd0, j, k}, 0);
    chk("abort_synced", {31'd0, synced}, 0);
    chk("abort_ready", {31'd0, cmd_ready}, 1);
    chk("abort_busy", {31'd0, busy}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send(2'd2, 1, 0);
    wait_idle();
    chk("post_abort_exp_q", {31'd0, exp_q}, 1);
    chk("post_abort_err", {31'd0, err}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
